// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: resolves load-use,
// taken-branch and multi-cycle data-memory hazards and counts stall cycles.
module hazard_stall_ctrl #(
   parameter int MEM_LAT = 2,
   parameter int STAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        ID_RsAddr,
   input  logic [4:0]        ID_RtAddr,
   input  logic              EX_MemRead,
   input  logic [4:0]        EX_RtAddr,
   input  logic              EX_BranchTaken,
   input  logic              MEM_MemRead,
   input  logic              MEM_MemWrite,
   output logic              PC_en,
   output logic              IF_ID_en,
   output logic              IF_ID_flush,
   output logic              ID_EX_en,
   output logic              ID_EX_flush,
   output logic              EX_MEM_en,
   output logic              MEM_WB_bubble,
   output logic              MemBusy,
   output logic [STAT_W-1:0] StallCount
);

   localparam int WC_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
   localparam logic [WC_W-1:0] WC_INIT = WC_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

   // Control vector: {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_bubble, MemBusy}
   localparam logic [7:0] CTL_IDLE   = 8'b1101_0100;
   localparam logic [7:0] CTL_FREEZE = 8'b0000_0010;
   localparam logic [7:0] CTL_BRANCH = 8'b1111_1100;
   localparam logic [7:0] CTL_LDUSE  = 8'b0001_1100;
   localparam logic [7:0] CTL_BUSY   = 8'b0000_0001;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [WC_W-1:0]    wait_cnt_r;
   logic [WC_W-1:0]    wait_cnt_s;
   logic [STAT_W-1:0]  stall_count_r;
   logic [7:0]         ctl_s;
   logic [7:0]         ctl_out_s;
   logic               mem_req_s;
   logic               load_use_s;

   assign mem_req_s  = (MEM_LAT > 1) ? (MEM_MemRead | MEM_MemWrite) : 1'b0;
   assign load_use_s = EX_MemRead && (EX_RtAddr != 5'd0) &&
                       ((EX_RtAddr == ID_RsAddr) || (EX_RtAddr == ID_RtAddr));

   // Next-state, wait counter and pipeline control decode.
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      ctl_s      = CTL_IDLE;
      case (state_r)
         RUN: begin
            if (mem_req_s) begin
               ctl_s      = CTL_FREEZE;
               wait_cnt_s = WC_INIT;
               state_s    = MEMWAIT;
            end else if (EX_BranchTaken) begin
               ctl_s = CTL_BRANCH;
            end else if (load_use_s) begin
               ctl_s = CTL_LDUSE;
            end else begin
               ctl_s = CTL_IDLE;
            end
         end
         MEMWAIT: begin
            if (wait_cnt_r != '0) begin
               ctl_s      = CTL_FREEZE | CTL_BUSY;
               wait_cnt_s = wait_cnt_r - WC_W'(1);
            end else begin
               // Release: hazards held in EX during the freeze are resolved now.
               state_s = RUN;
               if (EX_BranchTaken) begin
                  ctl_s = CTL_BRANCH | CTL_BUSY;
               end else if (load_use_s) begin
                  ctl_s = CTL_LDUSE | CTL_BUSY;
               end else begin
                  ctl_s = CTL_IDLE | CTL_BUSY;
               end
            end
         end
         default: begin
            state_s    = RUN;
            wait_cnt_s = '0;
            ctl_s      = CTL_IDLE;
         end
      endcase
   end

   assign ctl_out_s = rst_n ? ctl_s : CTL_IDLE;

   assign PC_en         = ctl_out_s[7];
   assign IF_ID_en      = ctl_out_s[6];
   assign IF_ID_flush   = ctl_out_s[5];
   assign ID_EX_en      = ctl_out_s[4];
   assign ID_EX_flush   = ctl_out_s[3];
   assign EX_MEM_en     = ctl_out_s[2];
   assign MEM_WB_bubble = ctl_out_s[1];
   assign MemBusy       = ctl_out_s[0];
   assign StallCount    = stall_count_r;

   // FSM state and wait counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= RUN;
         wait_cnt_r <= '0;
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_r <= '0;
      end else if (!ctl_s[7] && (stall_count_r != {STAT_W{1'b1}})) begin
         stall_count_r <= stall_count_r + STAT_W'(1);
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (MEM_LAT=3, STAT_W=4): directed
// vectors push hand-computed control words; a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

   localparam logic [7:0] IDLE   = 8'b1101_0100;
   localparam logic [7:0] FRZ    = 8'b0000_0010;
   localparam logic [7:0] FRZ_B  = 8'b0000_0011;
   localparam logic [7:0] BR     = 8'b1111_1100;
   localparam logic [7:0] LU     = 8'b0001_1100;
   localparam logic [7:0] REL    = 8'b1101_0101;
   localparam logic [7:0] REL_BR = 8'b1111_1101;
   localparam logic [7:0] REL_LU = 8'b0001_1101;

   typedef struct {
      string      tag;
      logic [7:0] ctl;
      logic [3:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
   logic       ex_mr = 1'b0, ex_br = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
   logic       pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, mwb_bub, busy;
   logic [3:0] stall_cnt;

   exp_t       sb[$];
   logic [3:0] exp_cnt = 4'd0;
   int         checks = 0;
   int         errors = 0;

   hazard_stall_ctrl #(.MEM_LAT(3), .STAT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ID_RsAddr(id_rs), .ID_RtAddr(id_rt),
      .EX_MemRead(ex_mr), .EX_RtAddr(ex_rt), .EX_BranchTaken(ex_br),
      .MEM_MemRead(mem_rd), .MEM_MemWrite(mem_wr),
      .PC_en(pc_en), .IF_ID_en(ifid_en), .IF_ID_flush(ifid_fl),
      .ID_EX_en(idex_en), .ID_EX_flush(idex_fl), .EX_MEM_en(exmem_en),
      .MEM_WB_bubble(mwb_bub), .MemBusy(busy), .StallCount(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic step(input string tag, input logic rst,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr_ex, input logic [4:0] rt_ex, input logic br,
                       input logic rd, input logic wr, input logic [7:0] ctl);
      exp_t e;
      @(posedge clk);
      #2;
      rst_n = rst; id_rs = rs; id_rt = rt; ex_mr = mr_ex; ex_rt = rt_ex;
      ex_br = br; mem_rd = rd; mem_wr = wr;
      if (!rst) exp_cnt = 4'd0;
      e.tag = tag; e.ctl = ctl; e.cnt = exp_cnt;
      sb.push_back(e);
      if (rst && !ctl[7] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
   endtask

   // Monitor: compare every issued expectation half a cycle after it is driven.
   initial begin
      exp_t e;
      logic [7:0] act;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            act = {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, mwb_bub, busy};
            checks++;
            if (act !== e.ctl || stall_cnt !== e.cnt) begin
               errors++;
               $display("FAIL %s: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                        e.tag, act, stall_cnt, e.ctl, e.cnt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      step("reset_idle",    1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
      step("run_idle",      1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
      step("lu_rs",         1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, LU);
      step("after_lu",      1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
      step("lu_rt",         1'b1, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, LU);
      step("lu_zero_reg",   1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
      step("lu_no_match",   1'b1, 5'd7, 5'd6, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, IDLE);
      step("no_load",       1'b1, 5'd8, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, IDLE);
      step("branch",        1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, BR);
      step("branch_over_lu",1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, BR);
      step("mem_start",     1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
      step("mem_wait",      1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ_B);
      step("mem_release",   1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, REL);
      step("after_release", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
      step("memw_start",    1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ);
      step("br_in_wait",    1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, FRZ_B);
      step("br_at_release", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, REL_BR);
      step("b2b_start",     1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, FRZ);
      step("lu_in_wait",    1'b1, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, FRZ_B);
      step("lu_at_release", 1'b1, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, REL_LU);
      step("post_lu_rel",   1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
      step("rst_mem_start", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ);
      step("rst_mid_wait",  1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, IDLE);
      step("rst_held",      1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, IDLE);
      step("rst_back_run",  1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
      for (int i = 0; i < 20; i++)
         step("sat_lu",     1'b1, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, LU);
      step("sat_hold",      1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);
      step("sat_final",     1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, IDLE);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries pending, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
